// File: rtl/exdes_axi_wr_responder.sv
// AXI4 write-channel responder for the ERNIC capsule DDR write master.
// Queues AW bursts, accepts W beats against the head burst, flags WLAST
// placement errors and returns in-order B responses. Payload is dropped.
module exdes_axi_wr_responder #(
  parameter int C_AXI_THREAD_ID_WIDTH = 1,
  parameter int C_AXI_ADDR_WIDTH      = 32,
  parameter int C_AXI_DATA_WIDTH      = 512,
  parameter int C_OUTSTANDING         = 4
) (
  input  logic                                core_clk,
  input  logic                                core_areset,
  input  logic [C_AXI_THREAD_ID_WIDTH-1:0]    capsule_ddr_s_axi_awid,
  input  logic [C_AXI_ADDR_WIDTH-1:0]         capsule_ddr_s_axi_awaddr,
  input  logic [7:0]                          capsule_ddr_s_axi_awlen,
  input  logic                                capsule_ddr_s_axi_awvalid,
  output logic                                capsule_ddr_s_axi_awready,
  input  logic [C_AXI_DATA_WIDTH-1:0]         capsule_ddr_s_axi_wdata,
  input  logic [C_AXI_DATA_WIDTH/8-1:0]       capsule_ddr_s_axi_wstrb,
  input  logic                                capsule_ddr_s_axi_wlast,
  input  logic                                capsule_ddr_s_axi_wvalid,
  output logic                                capsule_ddr_s_axi_wready,
  output logic [C_AXI_THREAD_ID_WIDTH-1:0]    capsule_ddr_s_axi_bid,
  output logic [1:0]                          capsule_ddr_s_axi_bresp,
  output logic                                capsule_ddr_s_axi_bvalid,
  input  logic                                capsule_ddr_s_axi_bready,
  output logic [15:0]                         burst_done_cnt,
  output logic [7:0]                          wlast_err_cnt
);

  localparam int IW = C_AXI_THREAD_ID_WIDTH;
  localparam int PW = $clog2(C_OUTSTANDING);
  localparam logic [PW:0]   DEPTH    = (PW+1)'(C_OUTSTANDING);
  localparam logic [PW:0]   CNT_ZERO = (PW+1)'(0);
  localparam logic [PW:0]   CNT_ONE  = (PW+1)'(1);
  localparam logic [PW-1:0] PTR_ONE  = PW'(1);

  // run_q keeps both ready outputs low while reset is held
  logic          run_q, run_d;
  logic [IW-1:0] aw_id_q  [C_OUTSTANDING];
  logic [IW-1:0] aw_id_d  [C_OUTSTANDING];
  logic [7:0]    aw_len_q [C_OUTSTANDING];
  logic [7:0]    aw_len_d [C_OUTSTANDING];
  logic [PW-1:0] aw_wp_q, aw_wp_d, aw_rp_q, aw_rp_d;
  logic [PW:0]   aw_cnt_q, aw_cnt_d;
  logic [IW-1:0] b_id_q   [C_OUTSTANDING];
  logic [IW-1:0] b_id_d   [C_OUTSTANDING];
  logic [1:0]    b_resp_q [C_OUTSTANDING];
  logic [1:0]    b_resp_d [C_OUTSTANDING];
  logic [PW-1:0] b_wp_q, b_wp_d, b_rp_q, b_rp_d;
  logic [PW:0]   b_cnt_q, b_cnt_d;
  logic [7:0]    beat_idx_q, beat_idx_d;
  logic          err_q, err_d;
  logic [15:0]   done_cnt_q, done_cnt_d;
  logic [7:0]    err_cnt_q, err_cnt_d;

  logic aw_full_s, aw_empty_s, b_full_s, b_empty_s;
  logic aw_push_s, w_hs_s, is_final_s, final_hs_s, beat_err_s, b_pop_s;
  logic unused_s;

  assign aw_full_s  = (aw_cnt_q == DEPTH);
  assign aw_empty_s = (aw_cnt_q == CNT_ZERO);
  assign b_full_s   = (b_cnt_q == DEPTH);
  assign b_empty_s  = (b_cnt_q == CNT_ZERO);

  assign capsule_ddr_s_axi_awready = run_q & ~aw_full_s;
  assign capsule_ddr_s_axi_wready  = run_q & ~aw_empty_s & ~b_full_s;
  assign capsule_ddr_s_axi_bvalid  = ~b_empty_s;
  assign capsule_ddr_s_axi_bid     = b_id_q[b_rp_q];
  assign capsule_ddr_s_axi_bresp   = b_resp_q[b_rp_q];
  assign burst_done_cnt            = done_cnt_q;
  assign wlast_err_cnt             = err_cnt_q;

  assign aw_push_s  = capsule_ddr_s_axi_awvalid & capsule_ddr_s_axi_awready;
  assign w_hs_s     = capsule_ddr_s_axi_wvalid & capsule_ddr_s_axi_wready;
  // Burst length comes from AWLEN alone; WLAST only feeds the error check
  assign is_final_s = (beat_idx_q == aw_len_q[aw_rp_q]);
  assign final_hs_s = w_hs_s & is_final_s;
  assign beat_err_s = capsule_ddr_s_axi_wlast ^ is_final_s;
  assign b_pop_s    = capsule_ddr_s_axi_bvalid & capsule_ddr_s_axi_bready;

  assign unused_s = ^{capsule_ddr_s_axi_awaddr, capsule_ddr_s_axi_wdata,
                      capsule_ddr_s_axi_wstrb};

  // Next-state computation for both queues, the beat tracker and counters
  always_comb begin
    run_d      = 1'b1;
    aw_id_d    = aw_id_q;
    aw_len_d   = aw_len_q;
    aw_wp_d    = aw_wp_q;
    aw_rp_d    = aw_rp_q;
    b_id_d     = b_id_q;
    b_resp_d   = b_resp_q;
    b_wp_d     = b_wp_q;
    b_rp_d     = b_rp_q;
    beat_idx_d = beat_idx_q;
    err_d      = err_q;
    done_cnt_d = done_cnt_q;
    err_cnt_d  = err_cnt_q;

    if (aw_push_s) begin
      aw_id_d[aw_wp_q]  = capsule_ddr_s_axi_awid;
      aw_len_d[aw_wp_q] = capsule_ddr_s_axi_awlen;
      aw_wp_d           = aw_wp_q + PTR_ONE;
    end else begin
      aw_wp_d = aw_wp_q;
    end

    if (final_hs_s) begin
      aw_rp_d          = aw_rp_q + PTR_ONE;
      b_id_d[b_wp_q]   = aw_id_q[aw_rp_q];
      b_resp_d[b_wp_q] = (err_q | beat_err_s) ? 2'b10 : 2'b00;
      b_wp_d           = b_wp_q + PTR_ONE;
      beat_idx_d       = 8'd0;
      err_d            = 1'b0;
      if (done_cnt_q != 16'hFFFF) begin
        done_cnt_d = done_cnt_q + 16'd1;
      end else begin
        done_cnt_d = done_cnt_q;
      end
      if ((err_q | beat_err_s) && (err_cnt_q != 8'hFF)) begin
        err_cnt_d = err_cnt_q + 8'd1;
      end else begin
        err_cnt_d = err_cnt_q;
      end
    end else if (w_hs_s) begin
      beat_idx_d = beat_idx_q + 8'd1;
      err_d      = err_q | beat_err_s;
    end else begin
      beat_idx_d = beat_idx_q;
    end

    if (b_pop_s) begin
      b_rp_d = b_rp_q + PTR_ONE;
    end else begin
      b_rp_d = b_rp_q;
    end

    case ({aw_push_s, final_hs_s})
      2'b10:   aw_cnt_d = aw_cnt_q + CNT_ONE;
      2'b01:   aw_cnt_d = aw_cnt_q - CNT_ONE;
      default: aw_cnt_d = aw_cnt_q;
    endcase

    case ({final_hs_s, b_pop_s})
      2'b10:   b_cnt_d = b_cnt_q + CNT_ONE;
      2'b01:   b_cnt_d = b_cnt_q - CNT_ONE;
      default: b_cnt_d = b_cnt_q;
    endcase
  end

  // State registers; reset drops every queued burst and response
  always_ff @(posedge core_clk or posedge core_areset) begin
    if (core_areset) begin
      run_q      <= 1'b0;
      aw_wp_q    <= {PW{1'b0}};
      aw_rp_q    <= {PW{1'b0}};
      aw_cnt_q   <= CNT_ZERO;
      b_wp_q     <= {PW{1'b0}};
      b_rp_q     <= {PW{1'b0}};
      b_cnt_q    <= CNT_ZERO;
      beat_idx_q <= 8'd0;
      err_q      <= 1'b0;
      done_cnt_q <= 16'd0;
      err_cnt_q  <= 8'd0;
      for (int i = 0; i < C_OUTSTANDING; i++) begin
        aw_id_q[i]  <= {IW{1'b0}};
        aw_len_q[i] <= 8'd0;
        b_id_q[i]   <= {IW{1'b0}};
        b_resp_q[i] <= 2'b00;
      end
    end else begin
      run_q      <= run_d;
      aw_id_q    <= aw_id_d;
      aw_len_q   <= aw_len_d;
      aw_wp_q    <= aw_wp_d;
      aw_rp_q    <= aw_rp_d;
      aw_cnt_q   <= aw_cnt_d;
      b_id_q     <= b_id_d;
      b_resp_q   <= b_resp_d;
      b_wp_q     <= b_wp_d;
      b_rp_q     <= b_rp_d;
      b_cnt_q    <= b_cnt_d;
      beat_idx_q <= beat_idx_d;
      err_q      <= err_d;
      done_cnt_q <= done_cnt_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

endmodule

// File: tb/tb_exdes_axi_wr_responder.sv
// Scoreboard bench for exdes_axi_wr_responder: stimulus pushes expected
// {bid, bresp}; a monitor pops on every B handshake and compares.
module tb_exdes_axi_wr_responder;

  logic         clk = 1'b0;
  logic         rst;
  logic [0:0]   awid;
  logic [31:0]  awaddr;
  logic [7:0]   awlen;
  logic         awvalid, awready;
  logic [511:0] wdata;
  logic [63:0]  wstrb;
  logic         wlast, wvalid, wready;
  logic [0:0]   bid;
  logic [1:0]   bresp;
  logic         bvalid, bready;
  logic [15:0]  done_cnt;
  logic [7:0]   err_cnt;

  int total = 0;
  int bad   = 0;
  logic [2:0] sb[$];

  always #5 clk = ~clk;

  exdes_axi_wr_responder dut (
    .core_clk                  (clk),
    .core_areset               (rst),
    .capsule_ddr_s_axi_awid    (awid),
    .capsule_ddr_s_axi_awaddr  (awaddr),
    .capsule_ddr_s_axi_awlen   (awlen),
    .capsule_ddr_s_axi_awvalid (awvalid),
    .capsule_ddr_s_axi_awready (awready),
    .capsule_ddr_s_axi_wdata   (wdata),
    .capsule_ddr_s_axi_wstrb   (wstrb),
    .capsule_ddr_s_axi_wlast   (wlast),
    .capsule_ddr_s_axi_wvalid  (wvalid),
    .capsule_ddr_s_axi_wready  (wready),
    .capsule_ddr_s_axi_bid     (bid),
    .capsule_ddr_s_axi_bresp   (bresp),
    .capsule_ddr_s_axi_bvalid  (bvalid),
    .capsule_ddr_s_axi_bready  (bready),
    .burst_done_cnt            (done_cnt),
    .wlast_err_cnt             (err_cnt)
  );

  // B monitor: every accepted response must match the head expectation
  always @(negedge clk) begin
    logic [2:0] e;
    if (bvalid && bready) begin
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL b_unexpected: actual id=%0d resp=%0d required no response", bid, bresp);
      end else begin
        e = sb.pop_front();
        if ({bid, bresp} !== e) begin
          bad++;
          $display("FAIL b_resp: actual id=%0d resp=%0d required id=%0d resp=%0d",
                   bid, bresp, e[2], e[1:0]);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic send_aw(input logic id, input logic [7:0] len);
    logic ok = 1'b0;
    int n = 0;
    awid = id; awlen = len; awaddr = $urandom; awvalid = 1'b1;
    while (!ok && n < 100) begin
      @(negedge clk); ok = awready;
      @(posedge clk); #1; n++;
    end
    awvalid = 1'b0;
    chk("aw_handshake", 32'(ok), 32'd1);
  endtask

  task automatic send_w(input logic wl);
    logic ok = 1'b0;
    int n = 0;
    wlast = wl; wdata = {16{$urandom}}; wstrb = {2{$urandom}}; wvalid = 1'b1;
    while (!ok && n < 100) begin
      @(negedge clk); ok = wready;
      @(posedge clk); #1; n++;
    end
    wvalid = 1'b0; wlast = 1'b0;
    chk("w_handshake", 32'(ok), 32'd1);
  endtask

  // Full burst: AW, expectation, then beats with wlast taken from pattern bits
  task automatic burst(input logic id, input logic [7:0] len, input logic [7:0] wl_pat,
                       input logic [1:0] exp_resp);
    send_aw(id, len);
    sb.push_back({id, exp_resp});
    for (int i = 0; i <= int'(len); i++) send_w(wl_pat[i]);
  endtask

  task automatic drain;
    int n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clk); n++;
    end
    chk("sb_drain", 32'(sb.size()), 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b1; awid = 1'b0; awaddr = 32'd0; awlen = 8'd0; awvalid = 1'b0;
    wdata = 512'd0; wstrb = 64'd0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_awready", 32'(awready), 32'd0);
    chk("rst_wready",  32'(wready),  32'd0);
    chk("rst_bvalid",  32'(bvalid),  32'd0);
    chk("rst_bid_bresp", 32'({bid, bresp}), 32'd0);
    chk("rst_counts", {done_cnt, err_cnt, 8'd0}, 32'd0);
    @(posedge clk); #1; rst = 1'b0;
    @(posedge clk); #1;

    // 1: clean 4-beat burst, B one cycle after final beat
    burst(1'b1, 8'd3, 8'b0000_1000, 2'b00);
    @(negedge clk);
    chk("t1_bvalid_latency", 32'(bvalid), 32'd1);
    chk("t1_done_cnt", 32'(done_cnt), 32'd1);
    drain();

    // 2: early WLAST on beat 1 does not end the burst
    burst(1'b0, 8'd3, 8'b0000_1010, 2'b10);
    drain();
    chk("t2_err_cnt", 32'(err_cnt), 32'd1);
    chk("t2_done_cnt", 32'(done_cnt), 32'd2);

    // 3: single-beat bursts, missing then present WLAST
    burst(1'b1, 8'd0, 8'b0000_0000, 2'b10);
    burst(1'b0, 8'd0, 8'b0000_0001, 2'b00);
    drain();
    chk("t3_err_cnt", 32'(err_cnt), 32'd2);

    // 4: fill the AW queue, fifth AW waits until one burst completes
    for (int i = 0; i < 4; i++) begin
      send_aw(1'(i), 8'd0);
      sb.push_back({1'(i), 2'b00});
    end
    @(negedge clk);
    chk("t4_aw_full", 32'(awready), 32'd0);
    @(posedge clk); #1;
    awid = 1'b1; awlen = 8'd0; awvalid = 1'b1;
    repeat (2) @(negedge clk);
    chk("t4_aw_full_hold", 32'(awready), 32'd0);
    @(posedge clk); #1;
    send_w(1'b1);
    send_aw(1'b1, 8'd0);
    sb.push_back({1'b1, 2'b00});
    for (int i = 0; i < 4; i++) send_w(1'b1);
    drain();
    chk("t4_done_cnt", 32'(done_cnt), 32'd9);
    chk("t4_err_cnt", 32'(err_cnt), 32'd2);

    // 5: B queue full stalls W, B holds stable, then drains in AW order
    bready = 1'b0;
    for (int i = 0; i < 4; i++) burst(1'(~i), 8'd0, 8'b0000_0001, 2'b00);
    send_aw(1'b1, 8'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t5_wready_stall", 32'(wready), 32'd0);
      chk("t5_bvalid_hold", 32'(bvalid), 32'd1);
      chk("t5_bid_hold", 32'({bid, bresp}), 32'({1'b1, 2'b00}));
    end
    @(posedge clk); #1;
    bready = 1'b1;
    drain();
    sb.push_back({1'b1, 2'b00});
    send_w(1'b1);
    drain();
    chk("t5_done_cnt", 32'(done_cnt), 32'd14);

    // 6: reset in the middle of a burst discards it
    send_aw(1'b1, 8'd3);
    send_w(1'b0);
    send_w(1'b0);
    rst = 1'b1;
    @(negedge clk);
    chk("t6_rst_ready", 32'({awready, wready, bvalid}), 32'd0);
    chk("t6_rst_b", 32'({bid, bresp}), 32'd0);
    chk("t6_rst_counts", {done_cnt, err_cnt, 8'd0}, 32'd0);
    @(posedge clk); #1; rst = 1'b0;
    @(posedge clk); #1;
    burst(1'b0, 8'd1, 8'b0000_0010, 2'b00);
    drain();
    chk("t6_done_cnt", 32'(done_cnt), 32'd1);
    chk("t6_err_cnt", 32'(err_cnt), 32'd0);
    repeat (3) @(posedge clk);
    chk("t6_no_extra_b", 32'(bvalid), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
